mmio_bridge_n: RTL and testbench

Parametrised memory-mapped bus bridge between the CPU data port and NSLV peripheral/memory slaves. It replaces fixed-decode, zero-latency bridging with a valid/ready request, a one-beat response and per-slave acknowledge. Slaves may therefore take multiple cycles. The bridge decodes the address by base/mask, runs a request FSM, enforces a wait-state timeout and reports errors for unmapped or timed-out accesses. It sits between myCPU's bus port and DRAM, 7-seg, LED, switch and button interfaces.

---
 rtl/mmio_bridge_n.sv | 206 ++++++++++++++++++++
 tb/tb_mmio_bridge_n.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge_n.sv
// mmio_bridge_n: memory-mapped bridge from the CPU data port to NSLV slaves.
//   CPU side   : req_valid/req_ready handshake (we, addr, wdata, wstrb);
//                single-cycle rsp_valid pulse with rsp_rdata / rsp_err.
//   Slave side : one-hot slv_sel with latched we/addr/wdata/wstrb,
//                per-slave slv_ack and packed slv_rdata.
//   Status     : err_count (saturating at 255), err_addr (latest error).
// Decode is base/mask per slot, lowest index wins on overlap. A selected
// slave that does not ack within TIMEOUT cycles is released and the access
// completes with an error (TIMEOUT=0 waits forever).

// Address match for one slot.
module mmio_bridge_n_dec #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] MASK = 32'h0
) (
  input  logic [31:0] addr,
  output logic        hit
);
  assign hit = (addr & MASK) == BASE;
endmodule

module mmio_bridge_n #(
  parameter int                  NSLV     = 5,
  parameter int                  DW       = 32,
  parameter logic [NSLV*32-1:0]  SLV_BASE = {32'hFFFFF078, 32'hFFFFF070, 32'hFFFFF060,
                                             32'hFFFFF000, 32'h00000000},
  parameter logic [NSLV*32-1:0]  SLV_MASK = {32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF8,
                                             32'hFFFFFFF0, 32'hFFFF0000},
  parameter int                  TIMEOUT  = 15
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [DW-1:0]        req_wdata,
  input  logic [DW/8-1:0]      req_wstrb,
  output logic                 rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic [NSLV-1:0]      slv_sel,
  output logic                 slv_we,
  output logic [31:0]          slv_addr,
  output logic [DW-1:0]        slv_wdata,
  output logic [DW/8-1:0]      slv_wstrb,
  input  logic [NSLV-1:0]      slv_ack,
  input  logic [NSLV*DW-1:0]   slv_rdata,
  output logic [7:0]           err_count,
  output logic [31:0]          err_addr
);

  // Wide enough to hold TIMEOUT-1 for any TIMEOUT, including 0.
  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic            we;
    logic [31:0]     addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
  } req_t;

  state_e            state_q, state_d;
  req_t              slv_q, slv_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [NSLV-1:0]   slv_sel_q, slv_sel_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [31:0]       err_addr_q, err_addr_d;
  logic [CW-1:0]     wait_q, wait_d;

  logic [NSLV-1:0]   hit, hit_lo;
  logic [DW-1:0]     rd_mux;
  logic              ack_hit, tmo;

  // Per-slot decoders on the incoming request address.
  for (genvar i = 0; i < NSLV; i++) begin : g_dec
    mmio_bridge_n_dec #(
      .BASE (SLV_BASE[32*i +: 32]),
      .MASK (SLV_MASK[32*i +: 32])
    ) u_dec (
      .addr (req_addr),
      .hit  (hit[i])
    );
  end

  // Isolate the lowest set bit: lowest-index slot wins on overlap.
  assign hit_lo = hit & (~hit + NSLV'(1));

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NSLV; i++)
      if (slv_sel_q[i]) rd_mux = slv_rdata[i*DW +: DW];
  end

  // Only the selected slave's ack counts; an ack beats a same-cycle timeout.
  assign ack_hit = (state_q == ACCESS) && |(slv_ack & slv_sel_q);
  assign tmo     = (TIMEOUT != 0) && (state_q == ACCESS) && !ack_hit &&
                   (wait_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = (|hit) ? ACCESS : RESP;
      ACCESS:  if (ack_hit || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs (next values of the registered outputs)
  always_comb begin
    slv_d       = slv_q;
    slv_sel_d   = slv_sel_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    wait_d      = wait_q;
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          slv_d.we    = req_we;
          slv_d.addr  = req_addr;
          slv_d.wdata = req_wdata;
          slv_d.wstrb = req_wstrb;
          wait_d      = '0;
          if (|hit) begin
            slv_sel_d = hit_lo;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
            err_addr_d  = req_addr;
          end
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          slv_sel_d   = '0;
          rsp_rdata_d = slv_q.we ? '0 : rd_mux;
          rsp_err_d   = 1'b0;
        end else if (tmo) begin
          slv_sel_d   = '0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
          err_addr_d  = slv_q.addr;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      slv_q       <= '0;
      slv_sel_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
      wait_q      <= '0;
    end else begin
      slv_q       <= slv_d;
      slv_sel_q   <= slv_sel_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      wait_q      <= wait_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign slv_sel   = slv_sel_q;
  assign slv_we    = slv_q.we;
  assign slv_addr  = slv_q.addr;
  assign slv_wdata = slv_q.wdata;
  assign slv_wstrb = slv_q.wstrb;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mmio_bridge_n.sv
// Randomized + directed bench for mmio_bridge_n with a scoreboard queue.
module tb_mmio_bridge_n;
  localparam int NSLV = 5;
  localparam int DW   = 32;
  localparam int TMO  = 15;
  localparam logic [NSLV*32-1:0] BASE = {32'hFFFFF078, 32'hFFFFF070, 32'hFFFFF060,
                                         32'hFFFFF000, 32'h00000000};
  localparam logic [NSLV*32-1:0] MASK = {32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF8,
                                         32'hFFFFFFF0, 32'hFFFF0000};

  logic              cpu_clk, cpu_rst_n;
  logic              req_valid, req_ready, req_we;
  logic [31:0]       req_addr;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_wstrb;
  logic              rsp_valid, rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic [NSLV-1:0]   slv_sel, slv_ack;
  logic              slv_we;
  logic [31:0]       slv_addr;
  logic [DW-1:0]     slv_wdata;
  logic [DW/8-1:0]   slv_wstrb;
  logic [NSLV*DW-1:0] slv_rdata;
  logic [7:0]        err_count;
  logic [31:0]       err_addr;

  mmio_bridge_n #(.NSLV(NSLV), .DW(DW), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_wstrb(slv_wstrb), .slv_ack(slv_ack), .slv_rdata(slv_rdata),
    .err_count(err_count), .err_addr(err_addr));

  initial begin cpu_clk = 0; forever #5 cpu_clk = ~cpu_clk; end

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic [7:0]    cnt;
    logic [31:0]   addr;
    int            lat;
    int            acc;
  } exp_t;
  exp_t q[$];

  int nchk = 0, nerr = 0;
  int mcnt = 0;             // model error counter
  logic [31:0] maddr = 0;   // model error address

  // Current transaction seen by the slave model.
  int              cur_slot = -1, cur_delay = 0;
  logic            cur_we = 0;
  logic [31:0]     cur_addr = 0;
  logic [DW-1:0]   cur_wdata = 0, cur_rdata = 0;
  logic [DW/8-1:0] cur_wstrb = 0;
  bit              spur_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Lowest-index slot whose masked base matches, -1 if none.
  function automatic int decode(input logic [31:0] a);
    logic [31:0] b, m;
    for (int i = 0; i < NSLV; i++) begin
      b = BASE[32*i +: 32];
      m = MASK[32*i +: 32];
      if ((a & m) == b) return i;
    end
    return -1;
  endfunction

  // Slave model: selected slot acks after cur_delay selected cycles, other
  // slots may raise spurious acks; rdata on non-selected slots is noise.
  initial begin
    logic [NSLV-1:0]    a;
    logic [NSLV*DW-1:0] rdv;
    int                 sel_cnt;
    sel_cnt = 0; slv_ack = '0; slv_rdata = '0;
    forever begin
      @(negedge cpu_clk);
      a = spur_en ? NSLV'($urandom) : '0;
      for (int i = 0; i < NSLV; i++) rdv[i*DW +: DW] = DW'($urandom);
      if (slv_sel != '0 && cur_slot >= 0) begin
        a[cur_slot] = (sel_cnt == cur_delay);
        rdv[cur_slot*DW +: DW] = cur_rdata;
        sel_cnt++;
      end else sel_cnt = 0;
      slv_ack = a;
      slv_rdata = rdv;
    end
  end

  // Monitor: checks slave-side fields while selected and every response.
  initial begin
    exp_t e;
    logic [NSLV-1:0] oh;
    forever begin
      @(negedge cpu_clk);
      if (slv_sel != '0) begin
        oh = '0;
        if (cur_slot >= 0) oh[cur_slot] = 1'b1;
        chk("slv_sel", 64'(slv_sel), 64'(oh));
        chk("slv_addr", 64'(slv_addr), 64'(cur_addr));
        chk("slv_we", 64'(slv_we), 64'(cur_we));
        if (cur_we) begin
          chk("slv_wdata", 64'(slv_wdata), 64'(cur_wdata));
          chk("slv_wstrb", 64'(slv_wstrb), 64'(cur_wstrb));
        end
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("err_count", 64'(err_count), 64'(e.cnt));
          chk("err_addr", 64'(err_addr), 64'(e.addr));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("sel_in_resp", 64'(slv_sel), 64'd0);
          chk("ready_in_resp", 64'(req_ready), 64'd0);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [DW-1:0] wd,
                       input logic [DW/8-1:0] ws, input int dly, input logic [DW-1:0] rd,
                       input bit track);
    exp_t e;
    int   n, slot;
    n = 0;
    @(negedge cpu_clk);
    while (!req_ready && n < 200) begin @(negedge cpu_clk); n++; end
    if (!req_ready) begin
      nchk++; nerr++;
      $display("FAIL req_ready_wait: got req_ready=0 expected 1 within 200 cycles");
      return;
    end
    slot = decode(addr);
    cur_slot = slot; cur_we = we; cur_addr = addr; cur_wdata = wd; cur_wstrb = ws;
    cur_delay = dly; cur_rdata = rd;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    e.acc = cyc;
    if (slot < 0 || dly >= TMO) begin
      e.err = 1; e.rdata = '0;
      e.lat = (slot < 0) ? 1 : 1 + TMO;
      mcnt = (mcnt < 255) ? mcnt + 1 : 255;
      maddr = addr;
    end else begin
      e.err = 0; e.rdata = we ? '0 : rd;
      e.lat = 2 + dly;
    end
    e.cnt = 8'(mcnt); e.addr = maddr;
    if (track) q.push_back(e);
    // A request offered while busy must be ignored.
    @(negedge cpu_clk);
    req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
    @(negedge cpu_clk);
    req_valid = 0;
  endtask

  initial begin
    int r, k, dly;
    logic [31:0] a;
    cpu_rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    repeat (3) @(negedge cpu_clk);
    cpu_rst_n = 1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_slv_sel", 64'(slv_sel), 64'd0);
    chk("rst_slv_we", 64'(slv_we), 64'd0);
    chk("rst_slv_addr", 64'(slv_addr), 64'd0);
    chk("rst_slv_wdata", 64'(slv_wdata), 64'd0);
    chk("rst_slv_wstrb", 64'(slv_wstrb), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);

    // Directed cases
    issue(0, 32'hFFFFF070, '0, '0, 0, 32'h00A5A5A5, 1);
    issue(1, 32'h00000010, 32'h12345678, 4'hF, 3, '0, 1);
    issue(0, 32'h80000000, '0, '0, 0, '0, 1);
    issue(0, 32'hFFFFF000, '0, '0, 255, '0, 1);
    spur_en = 1;
    issue(0, 32'hFFFFF078, '0, '0, 2, 32'hCAFEF00D, 1);
    issue(0, 32'hFFFFF064, '0, '0, TMO - 1, 32'h0BADBEEF, 1);
    issue(1, 32'hFFFFF07C, 32'hDEADBEEF, 4'h3, TMO, '0, 1);

    // Randomized mix of mapped/unmapped, reads/writes, delays and timeouts
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, NSLV);
      if (r == NSLV) a = $urandom;
      else a = BASE[32*r +: 32] | (32'($urandom) & ~MASK[32*r +: 32]);
      k = $urandom_range(0, 9);
      dly = (k < 7) ? $urandom_range(0, 4) : (k == 7) ? TMO - 1 : (k == 8) ? TMO : 255;
      issue(1'($urandom), a, DW'($urandom), (DW/8)'($urandom), dly, DW'($urandom), 1);
    end

    // Reset during ACCESS: no response, state cleared, then normal operation.
    issue(0, 32'hFFFFF004, '0, '0, 255, '0, 0);
    repeat (2) @(negedge cpu_clk);
    chk("pre_rst_sel", 64'(slv_sel), 64'h2);
    cpu_rst_n = 0;
    @(negedge cpu_clk);
    cpu_rst_n = 1;
    mcnt = 0; maddr = 0;
    chk("midrst_slv_sel", 64'(slv_sel), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    issue(0, 32'hFFFFF074, '0, '0, 1, 32'h13572468, 1);

    // Saturation of the error counter
    spur_en = 0;
    for (int n = 0; n < 300; n++)
      issue(0, 32'h80000000 | (32'($urandom) & 32'h0FFFFFFF), '0, '0, 0, '0, 1);

    k = 0;
    while (q.size() != 0 && k < 2000) begin @(negedge cpu_clk); k++; end
    if (q.size() != 0) begin
      nchk++; nerr++;
      $display("FAIL drain: got %0d pending responses expected 0", q.size());
    end
    repeat (3) @(negedge cpu_clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
